audio_sample_mixer: RTL and testbench

- Audio stage between the sound sources (SuperSprite PSG, Mockingboard L/R, Apple speaker) and the HDMI encoder's audio input.
- Generates the 44.1 kHz audio strobe and converts the Apple speaker toggle into a bounded-length pulse so the HDMI line never carries a DC offset.
- Sums all sources per channel with saturation and presents registered stereo 16-bit samples plus a valid pulse.
- Runs entirely in the pixel clock domain; the speaker toggle arrives asynchronously from the logic clock domain.

---
 rtl/audio_sample_mixer.sv | 156 +++++++++++++++
 tb/tb_audio_sample_mixer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_mixer.sv
// Audio mixer in the pixel clock domain: 44.1 kHz strobe, speaker pulse envelope,
// and a three-stage saturating stereo mix feeding the HDMI audio input.
module audio_sample_mixer #(
    parameter int          CLOCK_SPEED_HZ = 27_000_000,
    parameter int          AUDIO_RATE     = 44100,
    parameter int          SPEAKER_HOLD   = 255,
    parameter logic [15:0] SPEAKER_LEVEL  = 16'h2000,
    parameter int          MB_SHIFT       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        speaker_toggle_i,
    input  logic        speaker_en_i,
    input  logic        mute_i,
    input  logic [15:0] ssp_audio_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    input  logic        clip_clr_i,
    output logic        clk_audio_o,
    output logic [15:0] sample_l_o,
    output logic [15:0] sample_r_o,
    output logic        sample_valid_o,
    output logic        clip_o
);
    localparam int DIV   = CLOCK_SPEED_HZ / AUDIO_RATE;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_divCnt;
    logic             r_clkAudio;
    logic             w_tick;

    logic       r_spkSync1, r_spkSync2, r_spkPrev;
    logic       r_spkPending, r_spkLevel;
    logic [7:0] r_spkCnt;
    logic       w_spkEdge, w_spkReload, w_spkLevelNext;
    logic [7:0] w_spkCntNext;
    logic [15:0] w_spkTerm;

    logic [17:0] r_s1Ssp, r_s1MbL, r_s1MbR, r_s1Spk;
    logic        r_s2Valid;
    logic [17:0] r_s2SumL, r_s2SumR;
    logic        w_satL, w_satR, w_clipSet;

    logic [15:0] r_sampleL, r_sampleR;
    logic        r_sampleValid, r_clip;

    assign w_tick = (r_divCnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divCnt   <= '0;
            r_clkAudio <= 1'b0;
        end else begin
            r_divCnt   <= w_tick ? '0 : r_divCnt + DIV_W'(1);
            r_clkAudio <= w_tick;
        end
    end

    assign w_spkEdge   = r_spkSync2 ^ r_spkPrev;
    assign w_spkReload = r_spkPending | w_spkEdge;

    // An edge seen in the tick cycle itself is folded into that tick's reload.
    always_comb begin
        w_spkCntNext   = r_spkCnt;
        w_spkLevelNext = r_spkLevel;
        if (w_tick) begin
            if (w_spkReload) begin
                w_spkCntNext   = 8'(SPEAKER_HOLD);
                w_spkLevelNext = r_spkSync2;
            end else if (r_spkCnt != 8'd0) begin
                w_spkCntNext = r_spkCnt - 8'd1;
            end
        end
    end

    assign w_spkTerm = (speaker_en_i && w_spkLevelNext && (w_spkCntNext != 8'd0))
                       ? SPEAKER_LEVEL : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spkSync1   <= 1'b0;
            r_spkSync2   <= 1'b0;
            r_spkPrev    <= 1'b0;
            r_spkPending <= 1'b0;
            r_spkLevel   <= 1'b0;
            r_spkCnt     <= 8'd0;
        end else begin
            r_spkSync1 <= speaker_toggle_i;
            r_spkSync2 <= r_spkSync1;
            r_spkPrev  <= r_spkSync2;
            r_spkCnt   <= w_spkCntNext;
            r_spkLevel <= w_spkLevelNext;
            if (w_tick) begin
                r_spkPending <= 1'b0;
            end else if (w_spkEdge) begin
                r_spkPending <= 1'b1;
            end
        end
    end

    assign w_satL    = (r_s2SumL > 18'h0FFFF);
    assign w_satR    = (r_s2SumR > 18'h0FFFF);
    assign w_clipSet = r_s2Valid && !mute_i && (w_satL || w_satR);

    // Capture on the strobe edge, sum one cycle later, saturate/mute on the third.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Ssp       <= '0;
            r_s1MbL       <= '0;
            r_s1MbR       <= '0;
            r_s1Spk       <= '0;
            r_s2Valid     <= 1'b0;
            r_s2SumL      <= '0;
            r_s2SumR      <= '0;
            r_sampleL     <= '0;
            r_sampleR     <= '0;
            r_sampleValid <= 1'b0;
            r_clip        <= 1'b0;
        end else begin
            if (w_tick) begin
                r_s1Ssp <= 18'(ssp_audio_i);
                r_s1MbL <= 18'(mb_audio_l_i) << MB_SHIFT;
                r_s1MbR <= 18'(mb_audio_r_i) << MB_SHIFT;
                r_s1Spk <= 18'(w_spkTerm);
            end
            r_s2Valid <= r_clkAudio;
            if (r_clkAudio) begin
                r_s2SumL <= r_s1Ssp + r_s1MbL + r_s1Spk;
                r_s2SumR <= r_s1Ssp + r_s1MbR + r_s1Spk;
            end
            r_sampleValid <= r_s2Valid;
            if (r_s2Valid) begin
                if (mute_i) begin
                    r_sampleL <= 16'h0000;
                    r_sampleR <= 16'h0000;
                end else begin
                    r_sampleL <= w_satL ? 16'hFFFF : r_s2SumL[15:0];
                    r_sampleR <= w_satR ? 16'hFFFF : r_s2SumR[15:0];
                end
            end
            if (w_clipSet) begin
                r_clip <= 1'b1;
            end else if (clip_clr_i) begin
                r_clip <= 1'b0;
            end
        end
    end

    assign clk_audio_o    = r_clkAudio;
    assign sample_l_o     = r_sampleL;
    assign sample_r_o     = r_sampleR;
    assign sample_valid_o = r_sampleValid;
    assign clip_o         = r_clip;

endmodule

// File: tb/tb_audio_sample_mixer.sv
// Bench for audio_sample_mixer: a short-divider instance checked every cycle against a
// sample-level model, plus a default-rate instance for the 612-clock timing.
module tb_audio_sample_mixer;
    localparam int FAST_HZ = 705_600;
    localparam int DIV_F   = 16;
    localparam int DIV_D   = 612;
    localparam int HOLD    = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        speaker_toggle_i, speaker_en_i, mute_i, clip_clr_i;
    logic [15:0] ssp_audio_i;
    logic [9:0]  mb_audio_l_i, mb_audio_r_i;

    logic        fStrobe, fValid, fClip;
    logic [15:0] fL, fR;
    logic        dStrobe, dValid, dClip;
    logic [15:0] dL, dR;

    always #5 clk = ~clk;

    audio_sample_mixer #(.CLOCK_SPEED_HZ(FAST_HZ)) dutFast (
        .clk(clk), .rst_n(rst_n),
        .speaker_toggle_i(speaker_toggle_i), .speaker_en_i(speaker_en_i),
        .mute_i(mute_i), .ssp_audio_i(ssp_audio_i),
        .mb_audio_l_i(mb_audio_l_i), .mb_audio_r_i(mb_audio_r_i),
        .clip_clr_i(clip_clr_i), .clk_audio_o(fStrobe),
        .sample_l_o(fL), .sample_r_o(fR),
        .sample_valid_o(fValid), .clip_o(fClip)
    );

    audio_sample_mixer dutDef (
        .clk(clk), .rst_n(rst_n),
        .speaker_toggle_i(speaker_toggle_i), .speaker_en_i(speaker_en_i),
        .mute_i(mute_i), .ssp_audio_i(ssp_audio_i),
        .mb_audio_l_i(mb_audio_l_i), .mb_audio_r_i(mb_audio_r_i),
        .clip_clr_i(clip_clr_i), .clk_audio_o(dStrobe),
        .sample_l_o(dL), .sample_r_o(dR),
        .sample_valid_o(dValid), .clip_o(dClip)
    );

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string tag);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting on the DUT (t=%0t)", tag, $time);
    endtask

    task automatic applyStimulus(input logic [15:0] ssp, input logic [9:0] mbl,
                                 input logic [9:0] mbr, input logic en, input logic mute);
        ssp_audio_i  = ssp;
        mb_audio_l_i = mbl;
        mb_audio_r_i = mbr;
        speaker_en_i = en;
        mute_i       = mute;
    endtask

    task automatic waitStrobe(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * DIV_F && !seen; i++) begin
            @(negedge clk);
            seen = (fStrobe === 1'b1);
        end
        if (!seen) reportTimeout(tag);
    endtask

    task automatic waitValid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * DIV_F && !seen; i++) begin
            @(negedge clk);
            seen = (fValid === 1'b1);
        end
        if (!seen) reportTimeout(tag);
    endtask

    // Returns at the valid cycle carrying inputs applied before the call.
    task automatic waitFresh(input string tag);
        waitStrobe(tag);
        waitValid(tag);
    endtask

    // Sample-level model of the fast instance: each strobe captures one sum,
    // which appears two clocks later; speaker pulse counted in sample ticks.
    typedef struct {
        int sumL;
        int sumR;
        int due;
    } pipeItem_t;

    pipeItem_t   pipeQ[$];
    pipeItem_t   mItem;
    int          mN, nD, cnt, mSpk;
    bit          d0, d1, d2, changed, lvl, mTick, mSet;
    logic        expStrobe, expValid, expClip;
    logic [15:0] expL, expR;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mN = 0; nD = 0; cnt = 0;
            d0 = 0; d1 = 0; d2 = 0; changed = 0; lvl = 0;
            expStrobe = 0; expValid = 0; expClip = 0; expL = 0; expR = 0;
            pipeQ.delete();
        end else begin
            mN++;
            nD++;
            if (d1 != d2) changed = 1;
            mTick = (mN % DIV_F) == 0;
            if (mTick) begin
                if (changed) begin
                    cnt = HOLD; lvl = d1; changed = 0;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
            d2 = d1; d1 = d0; d0 = speaker_toggle_i;
            mSet = 0;
            expValid = 0;
            if (pipeQ.size() > 0 && pipeQ[0].due == mN) begin
                mItem = pipeQ.pop_front();
                expValid = 1;
                if (mute_i) begin
                    expL = 16'h0000; expR = 16'h0000;
                end else begin
                    expL = (mItem.sumL > 65535) ? 16'hFFFF : 16'(mItem.sumL);
                    expR = (mItem.sumR > 65535) ? 16'hFFFF : 16'(mItem.sumR);
                    mSet = (mItem.sumL > 65535) || (mItem.sumR > 65535);
                end
            end
            if (mSet) expClip = 1;
            else if (clip_clr_i) expClip = 0;
            if (mTick) begin
                mSpk = (speaker_en_i && lvl && cnt != 0) ? 32'h2000 : 0;
                mItem.sumL = int'(ssp_audio_i) + int'(mb_audio_l_i) * 16 + mSpk;
                mItem.sumR = int'(ssp_audio_i) + int'(mb_audio_r_i) * 16 + mSpk;
                mItem.due  = mN + 2;
                pipeQ.push_back(mItem);
            end
            expStrobe = mTick;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("strobe", fStrobe, expStrobe);
            checkOutput("valid", fValid, expValid);
            checkOutput("sampleL", fL, expL);
            checkOutput("sampleR", fR, expR);
            checkOutput("clip", fClip, expClip);
            checkOutput("defStrobe", dStrobe, (nD > 0 && nD % DIV_D == 0));
            checkOutput("defValid", dValid, (nD >= DIV_D + 2 && (nD - 2) % DIV_D == 0));
        end
    end

    int strobeAt[$];
    int validAt[$];
    int hits, fFirst, dFirst;
    bit defSampled;

    initial begin
        rst_n = 1'b1;
        speaker_toggle_i = 1'b0;
        clip_clr_i = 1'b0;
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("resetL", fL, 16'h0000);
        checkOutput("resetValid", fValid, 1'b0);
        checkOutput("resetClip", fClip, 1'b0);
        checkOutput("resetDefStrobe", dStrobe, 1'b0);

        $display("[TB] divider and basic sum");
        applyStimulus(16'h1000, 10'h010, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        defSampled = 1'b0;
        for (int i = 1; i <= 3 * DIV_D + 4; i++) begin
            @(negedge clk);
            if (dStrobe === 1'b1) strobeAt.push_back(i);
            if (dValid === 1'b1) begin
                validAt.push_back(i);
                if (!defSampled) begin
                    checkOutput("defBasicL", dL, 16'h1100);
                    checkOutput("defBasicR", dR, 16'h1000);
                    defSampled = 1'b1;
                end
            end
        end
        checkOutput("defStrobeCount", strobeAt.size(), 3);
        checkOutput("defValidCount", validAt.size(), 3);
        for (int k = 0; k < strobeAt.size() && k < 3; k++)
            checkOutput("defStrobeAt", strobeAt[k], DIV_D * (k + 1));
        for (int k = 0; k < validAt.size() && k < 3; k++)
            checkOutput("defValidAt", validAt[k], DIV_D * (k + 1) + 2);
        checkOutput("basicL", fL, 16'h1100);
        checkOutput("basicR", fR, 16'h1000);
        checkOutput("basicClip", fClip, 1'b0);

        $display("[TB] saturation and clip");
        applyStimulus(16'hFF00, 10'h3FF, 10'h000, 1'b0, 1'b0);
        waitFresh("sat");
        checkOutput("satL", fL, 16'hFFFF);
        checkOutput("satR", fR, 16'hFF00);
        checkOutput("satClip", fClip, 1'b1);
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b0, 1'b0);
        waitFresh("drain");
        waitFresh("drain");
        checkOutput("clipHeld", fClip, 1'b1);
        clip_clr_i = 1'b1;
        @(negedge clk);
        clip_clr_i = 1'b0;
        checkOutput("clipCleared", fClip, 1'b0);
        applyStimulus(16'hFF00, 10'h3FF, 10'h000, 1'b0, 1'b0);
        clip_clr_i = 1'b1;
        waitFresh("setWins");
        checkOutput("clipSetWins", fClip, 1'b1);
        checkOutput("setWinsL", fL, 16'hFFFF);
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b0, 1'b0);
        waitFresh("drain2");
        @(negedge clk);
        clip_clr_i = 1'b0;
        checkOutput("clipClearedAgain", fClip, 1'b0);

        $display("[TB] speaker pulse");
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b1, 1'b0);
        speaker_toggle_i = 1'b1;
        hits = 0;
        for (int k = 0; k < HOLD + 8; k++) begin
            waitValid("spkOn");
            if (fL == 16'h2000 && fR == 16'h2000) hits++;
        end
        checkOutput("spkOnTicks", hits, HOLD);
        speaker_toggle_i = 1'b0;
        hits = 0;
        for (int k = 0; k < HOLD + 8; k++) begin
            waitValid("spkOff");
            if (fL != 16'h0000 || fR != 16'h0000) hits++;
        end
        checkOutput("spkOffTicks", hits, 0);

        $display("[TB] toggle on the tick cycle");
        waitStrobe("coin");
        repeat (DIV_F - 3) @(posedge clk);
        @(negedge clk);
        speaker_toggle_i = 1'b1;
        waitValid("coinFirst");
        checkOutput("coinFirstL", fL, 16'h2000);
        hits = (fL == 16'h2000) ? 1 : 0;
        for (int k = 0; k < HOLD + 6; k++) begin
            waitValid("coin");
            if (fL == 16'h2000) hits++;
        end
        checkOutput("coinTicks", hits, HOLD);
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b0, 1'b0);
        speaker_toggle_i = 1'b0;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) speaker_toggle_i = 1'b1;
            waitValid("spkDis");
            if (fL != 16'h0000) hits++;
        end
        checkOutput("spkDisabled", hits, 0);

        $display("[TB] reset mid-pipeline");
        applyStimulus(16'h1234, 10'h055, 10'h0AA, 1'b0, 1'b0);
        waitFresh("preRst");
        waitStrobe("rst");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstL", fL, 16'h0000);
        checkOutput("rstR", fR, 16'h0000);
        checkOutput("rstValid", fValid, 1'b0);
        checkOutput("rstDefL", dL, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fFirst = 0;
        dFirst = 0;
        for (int i = 1; i <= DIV_D + 10; i++) begin
            @(negedge clk);
            if (fValid === 1'b1 && fFirst == 0) fFirst = i;
            if (dValid === 1'b1 && dFirst == 0) dFirst = i;
        end
        checkOutput("rstFastFirst", fFirst, DIV_F + 2);
        checkOutput("rstDefFirst", dFirst, DIV_D + 2);

        $display("[TB] mute");
        applyStimulus(16'h8000, 10'h000, 10'h000, 1'b0, 1'b1);
        waitFresh("mute");
        checkOutput("muteL", fL, 16'h0000);
        checkOutput("muteR", fR, 16'h0000);
        applyStimulus(16'hFFFF, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
        waitFresh("muteSat");
        checkOutput("muteSatClip", fClip, 1'b0);

        $display("[TB] randomized traffic");
        speaker_en_i = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ssp_audio_i  = 16'($urandom);
            mb_audio_l_i = 10'($urandom);
            mb_audio_r_i = 10'($urandom);
            if ($urandom_range(0, 39) == 0) speaker_toggle_i = ~speaker_toggle_i;
            if ($urandom_range(0, 199) == 0) speaker_en_i = ~speaker_en_i;
            mute_i     = ($urandom_range(0, 3) == 0);
            clip_clr_i = ($urandom_range(0, 15) == 0);
        end
        applyStimulus(16'h0000, 10'h000, 10'h000, 1'b0, 1'b0);
        clip_clr_i = 1'b0;
        repeat (3 * DIV_F) @(negedge clk);
        checkEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
